// File: rtl/user_pkg.sv
// user_pkg: shared user-domain constants, OBI subordinate types and helpers
package user_pkg;

    localparam int unsigned EdgeDetMaxInputs = 32;
    localparam int unsigned ObiIdWidth       = 4;

    localparam logic [11:0] EdgeDetCtrlOffset   = 12'h000;
    localparam logic [11:0] EdgeDetRiseEnOffset = 12'h004;
    localparam logic [11:0] EdgeDetFallEnOffset = 12'h008;
    localparam logic [11:0] EdgeDetStatusOffset = 12'h00C;
    localparam logic [11:0] EdgeDetCountOffset  = 12'h010;
    localparam logic [11:0] EdgeDetLevelOffset  = 12'h014;

    localparam int unsigned EdgeDetCtrlEnableBit = 0;
    localparam int unsigned EdgeDetCtrlIrqEnBit  = 1;

    typedef struct packed {
        logic [31:0]           addr;
        logic                  we;
        logic [3:0]            be;
        logic [31:0]           wdata;
        logic [ObiIdWidth-1:0] aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        sbr_obi_a_chan_t a;
        logic            req;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [31:0]           rdata;
        logic [ObiIdWidth-1:0] rid;
        logic                  err;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        sbr_obi_r_chan_t r;
        logic            gnt;
        logic            rvalid;
    } sbr_obi_rsp_t;

    function automatic logic [5:0] edge_det_popcount(input logic [EdgeDetMaxInputs-1:0] v);
        edge_det_popcount = '0;
        for (int i = 0; i < EdgeDetMaxInputs; i++) edge_det_popcount += 6'(v[i]);
    endfunction

endpackage

// File: rtl/user_edge_detect_sync.sv
// user_edge_detect_sync: two-flop synchroniser for asynchronous input lines
module user_edge_detect_sync #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] async_data,
    output logic [Width-1:0] sync_data
);

    logic [Width-1:0] meta_q;

    // Two flops in series to settle metastability before the lines are used
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q    <= '0;
            sync_data <= '0;
        end else begin
            meta_q    <= async_data;
            sync_data <= meta_q;
        end
    end

endmodule

// File: rtl/user_edge_detect.sv
// user_edge_detect: OBI-mapped edge detector with sticky status, event counter and irq
module user_edge_detect
    import user_pkg::*;
#(
    parameter int unsigned NumInputs = 8,
    parameter type         obi_req_t = user_pkg::sbr_obi_req_t,
    parameter type         obi_rsp_t = user_pkg::sbr_obi_rsp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  obi_req_t             obi_req_i,
    output obi_rsp_t             obi_rsp_o,
    input  logic [NumInputs-1:0] edge_i,
    output logic                 irq_o
);

    logic [NumInputs-1:0]  sync_q, prev_q, rise_en_q, fall_en_q, status_q, evt, wmask, wdata_n, clr;
    logic [1:0]            ctrl_q;
    logic [31:0]           count_q, count_d, bmask, rdata, rdata_q;
    logic [32:0]           count_sum;
    logic [11:0]           offset;
    logic [ObiIdWidth-1:0] rid_q;
    logic                  rvalid_q, err_q, err, wr, unused_bits;

    user_edge_detect_sync #(.Width(NumInputs)) i_sync (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .async_data (edge_i),
        .sync_data  (sync_q)
    );

    assign offset  = {obi_req_i.a.addr[11:2], 2'b00};
    assign bmask   = {{8{obi_req_i.a.be[3]}}, {8{obi_req_i.a.be[2]}}, {8{obi_req_i.a.be[1]}}, {8{obi_req_i.a.be[0]}}};
    assign wmask   = bmask[NumInputs-1:0];
    assign wdata_n = obi_req_i.a.wdata[NumInputs-1:0];
    assign err     = obi_req_i.req & ((offset > EdgeDetLevelOffset) | (obi_req_i.a.we & (offset == EdgeDetLevelOffset)));
    assign wr      = obi_req_i.req & obi_req_i.a.we & ~err;
    assign unused_bits = ^{obi_req_i.a.addr, obi_req_i.a.wdata, bmask};

    assign evt = ((sync_q & ~prev_q & rise_en_q) | (~sync_q & prev_q & fall_en_q))
                 & {NumInputs{ctrl_q[EdgeDetCtrlEnableBit]}};
    assign clr = (wr && offset == EdgeDetStatusOffset) ? (wdata_n & wmask) : '0;
    assign count_sum = {1'b0, (wr && offset == EdgeDetCountOffset) ? 32'd0 : count_q}
                       + 33'(edge_det_popcount(32'(evt)));
    assign count_d = count_sum[32] ? 32'hFFFF_FFFF : count_sum[31:0];
    assign irq_o   = ctrl_q[EdgeDetCtrlIrqEnBit] & |status_q;

    // Register read mux; unmapped offsets return zero
    always_comb begin
        rdata = offset == EdgeDetCtrlOffset   ? 32'(ctrl_q)    :
                offset == EdgeDetRiseEnOffset ? 32'(rise_en_q) :
                offset == EdgeDetFallEnOffset ? 32'(fall_en_q) :
                offset == EdgeDetStatusOffset ? 32'(status_q)  :
                offset == EdgeDetCountOffset  ? count_q        :
                offset == EdgeDetLevelOffset  ? 32'(sync_q)    : 32'd0;
    end

    // Register file and detection state; new events override a same-cycle W1C
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_q    <= '0;
            ctrl_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            count_q   <= '0;
        end else begin
            prev_q   <= sync_q;
            status_q <= (status_q & ~clr) | evt;
            count_q  <= count_d;
            if (wr && offset == EdgeDetCtrlOffset)
                ctrl_q <= (ctrl_q & ~bmask[1:0]) | (obi_req_i.a.wdata[1:0] & bmask[1:0]);
            if (wr && offset == EdgeDetRiseEnOffset)
                rise_en_q <= (rise_en_q & ~wmask) | (wdata_n & wmask);
            if (wr && offset == EdgeDetFallEnOffset)
                fall_en_q <= (fall_en_q & ~wmask) | (wdata_n & wmask);
        end
    end

    // Response channel: one-cycle registered reply to every granted request
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= obi_req_i.req;
            err_q    <= err;
            rid_q    <= obi_req_i.a.aid;
            rdata_q  <= (obi_req_i.req & ~obi_req_i.a.we & ~err) ? rdata : 32'd0;
        end
    end

    // Zero-wait-state grant plus the registered response fields
    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = obi_req_i.req;
        obi_rsp_o.rvalid  = rvalid_q;
        obi_rsp_o.r.rdata = rdata_q;
        obi_rsp_o.r.rid   = rid_q;
        obi_rsp_o.r.err   = err_q;
    end

endmodule

// File: tb/tb_user_edge_detect.sv
// tb_user_edge_detect: directed self-checking bench for user_edge_detect
module tb_user_edge_detect;
    import user_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    sbr_obi_req_t obi_req;
    sbr_obi_rsp_t obi_rsp;
    logic [7:0]   edge_i;
    logic         irq_o;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  tid = '0;
    logic [31:0] rdat;
    logic        rerr;

    user_edge_detect #(.NumInputs(8)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .obi_req_i (obi_req),
        .obi_rsp_o (obi_rsp),
        .edge_i    (edge_i),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [11:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        @(negedge clk_i);
        tid = tid + 4'd1;
        obi_req.req     = 1'b1;
        obi_req.a.we    = we;
        obi_req.a.addr  = {20'h0, addr};
        obi_req.a.wdata = wdata;
        obi_req.a.be    = be;
        obi_req.a.aid   = tid;
        #1 check("gnt", 32'(obi_rsp.gnt), 32'd1);
        @(posedge clk_i);
        #1;
        obi_req.req = 1'b0;
        check("rvalid", 32'(obi_rsp.rvalid), 32'd1);
        check("rid", 32'(obi_rsp.r.rid), 32'(tid));
        rdat = obi_rsp.r.rdata;
        rerr = obi_rsp.r.err;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        bus(1'b0, addr, 32'd0, 4'hF);
        check(tag, rdat, exp);
        check({tag, "_err"}, 32'(rerr), 32'd0);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus(1'b1, addr, data, be);
        check("wr_err", 32'(rerr), 32'd0);
    endtask

    task automatic set_edges(input logic [7:0] v, input int settle);
        @(negedge clk_i);
        edge_i = v;
        repeat (settle) @(posedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_ni  = 1'b0;
        obi_req = '0;
        edge_i  = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_rvalid", 32'(obi_rsp.rvalid), 32'd0);
        check("rst_rdata", obi_rsp.r.rdata, 32'd0);
        check("rst_err", 32'(obi_rsp.r.err), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        rd("rst_ctrl",   EdgeDetCtrlOffset,   32'd0);
        rd("rst_rise",   EdgeDetRiseEnOffset, 32'd0);
        rd("rst_fall",   EdgeDetFallEnOffset, 32'd0);
        rd("rst_status", EdgeDetStatusOffset, 32'd0);
        rd("rst_count",  EdgeDetCountOffset,  32'd0);
        rd("rst_level",  EdgeDetLevelOffset,  32'd0);

        wr(EdgeDetCtrlOffset, 32'hFFFF_FFFF, 4'hF);
        rd("ctrl_rb", EdgeDetCtrlOffset, 32'h3);
        wr(EdgeDetRiseEnOffset, 32'hFFFF_FFFF, 4'hF);
        rd("rise_rb", EdgeDetRiseEnOffset, 32'hFF);
        wr(EdgeDetRiseEnOffset, 32'h0, 4'hE);
        rd("rise_be_off", EdgeDetRiseEnOffset, 32'hFF);
        wr(EdgeDetRiseEnOffset, 32'h0, 4'h1);
        rd("rise_be_on", EdgeDetRiseEnOffset, 32'h0);
        wr(EdgeDetRiseEnOffset, 32'h1, 4'hF);

        @(negedge clk_i);
        edge_i = 8'h01;
        @(posedge clk_i);
        @(posedge clk_i);
        #1 check("irq_k1", 32'(irq_o), 32'd0);
        @(posedge clk_i);
        #1 check("irq_k2", 32'(irq_o), 32'd1);
        rd("rise_status", EdgeDetStatusOffset, 32'h01);
        rd("rise_count",  EdgeDetCountOffset,  32'd1);
        wr(EdgeDetStatusOffset, 32'h01, 4'hF);
        check("irq_cleared", 32'(irq_o), 32'd0);
        rd("w1c_status", EdgeDetStatusOffset, 32'h0);
        set_edges(8'h00, 4);
        rd("no_fall_status", EdgeDetStatusOffset, 32'h0);
        wr(EdgeDetCountOffset, 32'h1234, 4'h0);
        rd("count_clr", EdgeDetCountOffset, 32'd0);

        wr(EdgeDetRiseEnOffset, 32'h0F, 4'hF);
        wr(EdgeDetFallEnOffset, 32'h0F, 4'hF);
        set_edges(8'h0F, 4);
        set_edges(8'h00, 4);
        rd("both_count",  EdgeDetCountOffset,  32'd8);
        rd("both_status", EdgeDetStatusOffset, 32'h0F);
        set_edges(8'hF0, 4);
        rd("level", EdgeDetLevelOffset, 32'hF0);
        set_edges(8'h00, 4);
        rd("masked_count",  EdgeDetCountOffset,  32'd8);
        rd("masked_status", EdgeDetStatusOffset, 32'h0F);

        set_edges(8'h04, 2);
        wr(EdgeDetStatusOffset, 32'h0F, 4'hF);
        rd("sim_w1c_status", EdgeDetStatusOffset, 32'h04);
        rd("sim_w1c_count",  EdgeDetCountOffset,  32'd9);
        set_edges(8'h0F, 2);
        wr(EdgeDetCountOffset, 32'hDEAD_BEEF, 4'hF);
        rd("sim_count_clr", EdgeDetCountOffset, 32'd3);
        rd("sim_status",    EdgeDetStatusOffset, 32'h0F);

        @(negedge clk_i);
        force dut.count_q = 32'hFFFF_FFFD;
        @(negedge clk_i);
        release dut.count_q;
        set_edges(8'h00, 4);
        rd("sat_count", EdgeDetCountOffset, 32'hFFFF_FFFF);
        set_edges(8'h0F, 4);
        rd("sat_hold", EdgeDetCountOffset, 32'hFFFF_FFFF);

        wr(EdgeDetCtrlOffset, 32'h2, 4'hF);
        wr(EdgeDetCountOffset, 32'h0, 4'hF);
        wr(EdgeDetStatusOffset, 32'hFF, 4'hF);
        set_edges(8'h00, 4);
        set_edges(8'h0F, 4);
        rd("dis_status", EdgeDetStatusOffset, 32'h0);
        rd("dis_count",  EdgeDetCountOffset,  32'd0);
        check("dis_irq", 32'(irq_o), 32'd0);
        wr(EdgeDetCtrlOffset, 32'h3, 4'hF);
        repeat (4) @(posedge clk_i);
        rd("en_status", EdgeDetStatusOffset, 32'h0);
        rd("en_count",  EdgeDetCountOffset,  32'd0);

        bus(1'b0, 12'h018, 32'd0, 4'hF);
        check("unmapped_err", 32'(rerr), 32'd1);
        check("unmapped_rdata", rdat, 32'd0);
        bus(1'b1, EdgeDetLevelOffset, 32'hFF, 4'hF);
        check("level_wr_err", 32'(rerr), 32'd1);
        check("level_wr_rdata", rdat, 32'd0);
        bus(1'b1, 12'h01C, 32'h0, 4'hF);
        check("unmapped_wr_err", 32'(rerr), 32'd1);
        rd("err_ctrl",  EdgeDetCtrlOffset,   32'h3);
        rd("err_rise",  EdgeDetRiseEnOffset, 32'h0F);
        rd("err_level", EdgeDetLevelOffset,  32'h0F);

        @(negedge clk_i);
        obi_req.req    = 1'b1;
        obi_req.a.we   = 1'b0;
        obi_req.a.be   = 4'hF;
        obi_req.a.addr = {20'h0, EdgeDetCtrlOffset};
        obi_req.a.aid  = 4'hA;
        @(posedge clk_i);
        #1;
        check("b2b_v0", 32'(obi_rsp.rvalid), 32'd1);
        check("b2b_rid0", 32'(obi_rsp.r.rid), 32'hA);
        check("b2b_d0", obi_rsp.r.rdata, 32'h3);
        obi_req.a.addr = {20'h0, EdgeDetRiseEnOffset};
        obi_req.a.aid  = 4'hB;
        @(posedge clk_i);
        #1;
        check("b2b_v1", 32'(obi_rsp.rvalid), 32'd1);
        check("b2b_rid1", 32'(obi_rsp.r.rid), 32'hB);
        check("b2b_d1", obi_rsp.r.rdata, 32'h0F);
        obi_req.a.addr = {20'h0, EdgeDetLevelOffset};
        obi_req.a.aid  = 4'hC;
        @(posedge clk_i);
        #1;
        check("b2b_v2", 32'(obi_rsp.rvalid), 32'd1);
        check("b2b_rid2", 32'(obi_rsp.r.rid), 32'hC);
        check("b2b_d2", obi_rsp.r.rdata, 32'h0F);
        obi_req.req = 1'b0;
        @(posedge clk_i);
        #1 check("b2b_idle", 32'(obi_rsp.rvalid), 32'd0);

        @(negedge clk_i);
        rst_ni         = 1'b0;
        obi_req.req    = 1'b1;
        obi_req.a.addr = {20'h0, EdgeDetCtrlOffset};
        @(posedge clk_i);
        #1;
        obi_req.req = 1'b0;
        check("rst_mid_rvalid", 32'(obi_rsp.rvalid), 32'd0);
        @(posedge clk_i);
        #1 check("rst_mid_rvalid2", 32'(obi_rsp.rvalid), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        rd("rst_mid_ctrl", EdgeDetCtrlOffset, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
